// File: rtl/fm_rssi_scan_mc.sv
// Multi-pair RSSI scanner: averages I^2+Q^2 over 2^LOG2_SAMPLES sample pairs per I/Q pair.
// Optional per-pair peak-power registers are enabled with the FM_RSSI_PEAK_EN macro.
module fm_rssi_scan_mc #(
  parameter int ADDR_WIDTH     = 13,
  parameter int ADC_WIDTH      = 12,
  parameter int SAMPLE_WIDTH   = 8,
  parameter int CH_WIDTH       = 3,
  parameter int NUM_PAIRS      = 2,
  parameter int LOG2_SAMPLES   = 12,
  parameter int RSSI_BASE_ADDR = 'h14,
  parameter int STATUS_ADDR    = 'h10
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic                  start_i,
  input  logic                  adc_valid_i,
  input  logic [CH_WIDTH-1:0]   adc_chan_i,
  input  logic [ADC_WIDTH-1:0]  adc_data_i,
  input  logic [ADDR_WIDTH-1:0] rdaddr_i,
  output logic [31:0]           rdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rssi_interrupt_o
);

  localparam int SW   = SAMPLE_WIDTH;
  localparam int PW   = 2 * SW;
  localparam int AW   = PW + LOG2_SAMPLES;
  localparam int CW   = LOG2_SAMPLES + 1;
  localparam int PIDX = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [CW-1:0] FULL = {1'b1, {LOG2_SAMPLES{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACQ, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   irq_q, irq_d;
  logic signed [SW-1:0]   iVal_q [NUM_PAIRS];
  logic signed [SW-1:0]   qVal_q [NUM_PAIRS];
  logic [NUM_PAIRS-1:0]   iOk_q, qOk_q;
  logic [AW-1:0]          acc_q [NUM_PAIRS];
  logic [CW-1:0]          cnt_q [NUM_PAIRS];
  logic [PW-1:0]          pwr_q, pwr_d;
  logic [PIDX-1:0]        pwrPair_q, pwrPair_d;
  logic                   pwrValid_q;
  logic [31:0]            rdata_q, rdata_d;

  logic [SW-1:0]          rawSample;
  logic signed [SW-1:0]   sample;
  logic [CH_WIDTH-2:0]    chPair;
  logic                   acceptBase;
  logic [NUM_PAIRS-1:0]   capI, capQ, formSel, accEn;
  logic                   found, allFull;
  logic signed [SW-1:0]   iSel, qSel;
  logic signed [PW-1:0]   iExt, qExt;

  // Offset-binary to two's complement is just an MSB flip of the kept bits.
  assign rawSample  = adc_data_i[ADC_WIDTH-1 -: SW];
  assign sample     = {~rawSample[SW-1], rawSample[SW-2:0]};
  assign chPair     = adc_chan_i[CH_WIDTH-1:1];
  assign acceptBase = adc_valid_i && !start_i && (state_q == ACQ);

  always_comb begin
    capI      = '0;
    capQ      = '0;
    formSel   = '0;
    accEn     = '0;
    found     = 1'b0;
    allFull   = 1'b1;
    iSel      = '0;
    qSel      = '0;
    pwrPair_d = '0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (acceptBase && chPair == (CH_WIDTH-1)'(p) && cnt_q[p] != FULL) begin
        capI[p] = adc_chan_i[0];
        capQ[p] = !adc_chan_i[0];
      end
      if (iOk_q[p] && qOk_q[p] && !found) begin
        found      = 1'b1;
        formSel[p] = 1'b1;
        pwrPair_d  = PIDX'(p);
        iSel       = iVal_q[p];
        qSel       = qVal_q[p];
      end
      accEn[p] = pwrValid_q && pwrPair_q == PIDX'(p) && cnt_q[p] != FULL;
      if (cnt_q[p] != FULL) allFull = 1'b0;
    end
  end

  assign iExt  = {{SW{iSel[SW-1]}}, iSel};
  assign qExt  = {{SW{qSel[SW-1]}}, qSel};
  assign pwr_d = PW'(iExt * iExt) + PW'(qExt * qExt);

  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    case (state_q)
      IDLE:    if (start_i) state_d = ACQ;
      ACQ:     if (!start_i && allFull) state_d = DONE;
      DONE:    if (start_i) state_d = ACQ;
      default: state_d = IDLE;
    endcase
    if (state_d == DONE && state_q != DONE) irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
    end
  end

  // Capture flags, power pipeline and accumulators; start wipes everything in flight.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      iOk_q      <= '0;
      qOk_q      <= '0;
      pwr_q      <= '0;
      pwrPair_q  <= '0;
      pwrValid_q <= 1'b0;
      for (int p = 0; p < NUM_PAIRS; p++) begin
        iVal_q[p] <= '0;
        qVal_q[p] <= '0;
        acc_q[p]  <= '0;
        cnt_q[p]  <= '0;
      end
    end else if (start_i) begin
      iOk_q      <= '0;
      qOk_q      <= '0;
      pwrValid_q <= 1'b0;
      for (int p = 0; p < NUM_PAIRS; p++) begin
        acc_q[p] <= '0;
        cnt_q[p] <= '0;
      end
    end else begin
      pwr_q      <= pwr_d;
      pwrPair_q  <= pwrPair_d;
      pwrValid_q <= found;
      for (int p = 0; p < NUM_PAIRS; p++) begin
        if (capI[p]) iVal_q[p] <= sample;
        if (capQ[p]) qVal_q[p] <= sample;
        iOk_q[p] <= capI[p] || (iOk_q[p] && !formSel[p]);
        qOk_q[p] <= capQ[p] || (qOk_q[p] && !formSel[p]);
        if (accEn[p]) begin
          acc_q[p] <= acc_q[p] + AW'(pwr_q);
          cnt_q[p] <= cnt_q[p] + 1'b1;
        end
      end
    end
  end

`ifdef FM_RSSI_PEAK_EN
  logic [PW-1:0] peak_q [NUM_PAIRS];

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int p = 0; p < NUM_PAIRS; p++) peak_q[p] <= '0;
    end else if (start_i) begin
      for (int p = 0; p < NUM_PAIRS; p++) peak_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PAIRS; p++)
        if (accEn[p] && pwr_q > peak_q[p]) peak_q[p] <= pwr_q;
    end
  end
`endif

  always_comb begin
    rdata_d = '0;
    if (rdaddr_i == ADDR_WIDTH'(STATUS_ADDR)) rdata_d = {30'b0, busy_o, done_o};
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (rdaddr_i == ADDR_WIDTH'(RSSI_BASE_ADDR + 4 * p))
        rdata_d = 32'(acc_q[p][AW-1 -: PW]);
`ifdef FM_RSSI_PEAK_EN
      if (rdaddr_i == ADDR_WIDTH'(RSSI_BASE_ADDR + 4 * NUM_PAIRS + 4 * p))
        rdata_d = 32'(peak_q[p]);
`endif
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata_o          = rdata_q;
  assign busy_o           = (state_q == ACQ);
  assign done_o           = (state_q == DONE);
  assign rssi_interrupt_o = irq_q;

endmodule

// File: tb/tb_fm_rssi_scan_mc.sv
// Directed bench for fm_rssi_scan_mc with LOG2_SAMPLES=4, SW=8, NUM_PAIRS=2.
// Peak-register expectations follow the FM_RSSI_PEAK_EN macro.
module tb_fm_rssi_scan_mc;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic        start = 1'b0;
  logic        adcValid = 1'b0;
  logic [2:0]  adcChan = '0;
  logic [11:0] adcData = '0;
  logic [12:0] rdAddr = '0;
  logic [31:0] rdata;
  logic        busy, done, irq;

  int compared = 0;
  int mismatched = 0;
  int irqCount = 0;
  int irqBefore;
  logic [31:0] rd;

  fm_rssi_scan_mc #(
    .ADDR_WIDTH(13), .ADC_WIDTH(12), .SAMPLE_WIDTH(8), .CH_WIDTH(3),
    .NUM_PAIRS(2), .LOG2_SAMPLES(4), .RSSI_BASE_ADDR('h14), .STATUS_ADDR('h10)
  ) dut (
    .clk(clk), .RSTn(RSTn), .start_i(start), .adc_valid_i(adcValid),
    .adc_chan_i(adcChan), .adc_data_i(adcData), .rdaddr_i(rdAddr),
    .rdata_o(rdata), .busy_o(busy), .done_o(done), .rssi_interrupt_o(irq)
  );

  always #5 clk = ~clk;

  // Interrupt cycles are tallied away from the active edge so pulse width can be checked.
  always @(negedge clk) if (irq) irqCount <= irqCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] ch, input logic [11:0] data);
    @(negedge clk);
    adcValid = 1'b1;
    adcChan  = ch;
    adcData  = data;
    @(negedge clk);
    adcValid = 1'b0;
  endtask

  task automatic pulseStart(input logic withSample);
    @(negedge clk);
    start    = 1'b1;
    adcValid = withSample;
    adcChan  = 3'd0;
    adcData  = 12'h000;
    @(negedge clk);
    start    = 1'b0;
    adcValid = 1'b0;
  endtask

  task automatic readReg(input logic [12:0] addr, output logic [31:0] data);
    @(negedge clk);
    rdAddr = addr;
    @(negedge clk);
    data = rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDone(input string tag);
    int budget = 30;
    while (!done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput(tag, {31'b0, done}, 32'h1);
  endtask

  initial begin
    // Reset state
    idle(3);
    checkOutput("reset busy", {31'b0, busy}, 32'h0);
    checkOutput("reset done", {31'b0, done}, 32'h0);
    checkOutput("reset irq", {31'b0, irq}, 32'h0);
    checkOutput("reset rdata", rdata, 32'h0);
    @(negedge clk) RSTn = 1'b1;
    readReg(13'h010, rd); checkOutput("reset status", rd, 32'h0);

    // Pair 0 only: I=127, Q=0
    irqBefore = irqCount;
    pulseStart(1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(3'd1, 12'hFF0);
      applyStimulus(3'd0, 12'h800);
    end
    idle(4);
    readReg(13'h014, rd); checkOutput("t1 mean0", rd, 32'h3F01);
    readReg(13'h018, rd); checkOutput("t1 mean1", rd, 32'h0);
    readReg(13'h010, rd); checkOutput("t1 status", rd, 32'h2);
    checkOutput("t1 no irq", irqCount - irqBefore, 0);
`ifdef FM_RSSI_PEAK_EN
    readReg(13'h01C, rd); checkOutput("t6 peak0", rd, 32'h3F01);
`else
    readReg(13'h01C, rd); checkOutput("t6 peak0 absent", rd, 32'h0);
`endif
    readReg(13'h020, rd); checkOutput("t6 peak1", rd, 32'h0);

    // Pair 1: I=Q=-128
    for (int i = 0; i < 16; i++) begin
      applyStimulus(3'd3, 12'h000);
      applyStimulus(3'd2, 12'h000);
    end
    waitDone("t2 done");
    idle(5);
    checkOutput("t2 irq once", irqCount - irqBefore, 1);
    readReg(13'h018, rd); checkOutput("t2 mean1", rd, 32'h8000);
    readReg(13'h014, rd); checkOutput("t2 mean0 held", rd, 32'h3F01);
    readReg(13'h010, rd); checkOutput("t2 status", rd, 32'h1);

    // I overwrite before Q arrives; surplus samples past 16 ignored
    pulseStart(1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(3'd1, 12'h900);
      applyStimulus(3'd1, 12'h880);
      applyStimulus(3'd0, 12'h800);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'd1, 12'hFF0);
      applyStimulus(3'd0, 12'h800);
    end
    idle(4);
    readReg(13'h014, rd); checkOutput("t3 mean0", rd, 32'h40);
    checkOutput("t3 busy", {31'b0, busy}, 32'h1);
    irqBefore = irqCount;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(3'd3, 12'h900);
      applyStimulus(3'd2, 12'h800);
    end
    waitDone("t3 done");
    idle(3);
    checkOutput("t3 irq once", irqCount - irqBefore, 1);
    readReg(13'h018, rd); checkOutput("t3 mean1", rd, 32'h100);
    readReg(13'h014, rd); checkOutput("t3 mean0 held", rd, 32'h40);

    // Restart mid-scan with a sample coincident with start
    pulseStart(1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'd1, 12'hFF0);
      applyStimulus(3'd0, 12'h800);
    end
    idle(4);
    readReg(13'h014, rd); checkOutput("t4 partial", rd, 32'h1F80);
    irqBefore = irqCount;
    pulseStart(1'b1);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(3'd1, 12'h880);
      applyStimulus(3'd0, 12'h800);
      applyStimulus(3'd3, 12'h900);
      applyStimulus(3'd2, 12'h800);
    end
    idle(4);
    checkOutput("t4 not done", {31'b0, done}, 32'h0);
    checkOutput("t4 no irq", irqCount - irqBefore, 0);
    applyStimulus(3'd1, 12'h880);
    applyStimulus(3'd0, 12'h800);
    applyStimulus(3'd3, 12'h900);
    applyStimulus(3'd2, 12'h800);
    waitDone("t4 done");
    idle(3);
    checkOutput("t4 irq once", irqCount - irqBefore, 1);
    readReg(13'h014, rd); checkOutput("t4 mean0", rd, 32'h40);
    readReg(13'h018, rd); checkOutput("t4 mean1", rd, 32'h100);

    // Asynchronous reset in the middle of a scan
    pulseStart(1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'd1, 12'hFF0);
      applyStimulus(3'd0, 12'h800);
    end
    idle(4);
    readReg(13'h014, rd); checkOutput("t5 pre mean0", rd, 32'hFC0);
    readReg(13'h010, rd); checkOutput("t5 pre status", rd, 32'h2);
    @(negedge clk);
    #2 RSTn = 1'b0;
    #1;
    checkOutput("t5 rdata", rdata, 32'h0);
    checkOutput("t5 busy", {31'b0, busy}, 32'h0);
    checkOutput("t5 done", {31'b0, done}, 32'h0);
    checkOutput("t5 irq", {31'b0, irq}, 32'h0);
    idle(2);
    RSTn = 1'b1;
    readReg(13'h014, rd); checkOutput("t5 mean0", rd, 32'h0);
    readReg(13'h010, rd); checkOutput("t5 status", rd, 32'h0);
    readReg(13'h1F0, rd); checkOutput("t5 unmapped", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
